// File: rtl/dispatch_queue_pkg.sv
// Shared decode-stage-2 definitions: format codes, functional-unit codes and the
// packed decoded-instruction entry that travels from decode into the dispatch queue.
package dispatch_queue_pkg;

    localparam int OPCODE_W    = 6;
    localparam int REG_W       = 5;
    localparam int ADDR_W      = 64;
    localparam int IMM_W       = 24;
    localparam int XO_W        = 10;
    localparam int FMT_W       = 5;
    localparam int REG_USE_W   = 2;
    localparam int FU_CODE_W   = 3;
    localparam int QUEUE_DEPTH = 4;
    localparam int FU_COUNT    = 8;

    typedef enum logic [FMT_W-1:0] {
        FMT_A, FMT_B, FMT_D, FMT_DQ, FMT_DS, FMT_DX, FMT_I, FMT_M,
        FMT_MD, FMT_MDS, FMT_SC, FMT_VA, FMT_VC, FMT_VX, FMT_X, FMT_XFL,
        FMT_XFX, FMT_XL, FMT_XO, FMT_XS, FMT_Z22, FMT_Z23, FMT_INVALID
    } format_e;

    localparam logic [FU_CODE_W-1:0] FU_BRANCH  = 3'd0;
    localparam logic [FU_CODE_W-1:0] FU_INT0    = 3'd1;
    localparam logic [FU_CODE_W-1:0] FU_INT1    = 3'd2;
    localparam logic [FU_CODE_W-1:0] FU_MULDIV  = 3'd3;
    localparam logic [FU_CODE_W-1:0] FU_LOAD    = 3'd4;
    localparam logic [FU_CODE_W-1:0] FU_STORE   = 3'd5;
    localparam logic [FU_CODE_W-1:0] FU_FPU     = 3'd6;
    localparam logic [FU_CODE_W-1:0] FU_SYSTEM  = 3'd7;

    typedef struct packed {
        logic [ADDR_W-1:0]    instruction_address;
        logic [OPCODE_W-1:0]  opcode;
        logic [XO_W-1:0]      x_opcode;
        logic                 x_opcode_enable;
        logic [FMT_W-1:0]     instruction_format;
        logic [IMM_W-1:0]     imm;
        logic                 imm_enable;
        logic [REG_W-1:0]     reg1;
        logic [REG_W-1:0]     reg2;
        logic [REG_W-1:0]     reg3;
        logic [REG_USE_W-1:0] reg1_use;
        logic [REG_USE_W-1:0] reg2_use;
        logic [REG_USE_W-1:0] reg3_use;
        logic                 reg1_enable;
        logic                 reg2_enable;
        logic                 reg3_enable;
        logic                 reg3_is_immediate;
        logic                 bit1;
        logic                 bit2;
        logic                 bit1_enable;
        logic                 bit2_enable;
        logic                 reg2_val_or_zero;
        logic [FU_CODE_W-1:0] functional_unit_code;
    } dq_entry_t;

    localparam int ENTRY_W = $bits(dq_entry_t);

endpackage

// File: rtl/dispatch_fifo_mem.sv
// Entry storage for the dispatch queue: plain register array, one write port and one
// asynchronous read port. Contents are deliberately not reset.
module dispatch_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO between decode stage 2 and the functional units; the head entry
// is offered to exactly one unit with valid/ready, and decode is throttled through stall_o.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int opcodeWidth      = OPCODE_W,
    parameter int regWidth         = REG_W,
    parameter int addressSize      = ADDR_W,
    parameter int immWidth         = IMM_W,
    parameter int XxoOpcodeWidth   = XO_W,
    parameter int formatIndexRange = FMT_W,
    parameter int QueueDepth       = QUEUE_DEPTH,
    parameter int FuCount          = FU_COUNT,
    parameter int CntWidth         = $clog2(QueueDepth) + 1
) (
    input  logic                        clock_i,
    input  logic                        resetn_i,
    input  logic                        flush_i,
    input  logic                        enable_i,
    input  logic [addressSize-1:0]      instructionAddress_i,
    input  logic [opcodeWidth-1:0]      opcode_i,
    input  logic [XxoOpcodeWidth-1:0]   xOpcode_i,
    input  logic                        xOpcodeEnable_i,
    input  logic [formatIndexRange-1:0] instructionFormat_i,
    input  logic [immWidth-1:0]         imm_i,
    input  logic                        immEnable_i,
    input  logic [regWidth-1:0]         reg1_i,
    input  logic [regWidth-1:0]         reg2_i,
    input  logic [regWidth-1:0]         reg3_i,
    input  logic [1:0]                  reg1Use_i,
    input  logic [1:0]                  reg2Use_i,
    input  logic [1:0]                  reg3Use_i,
    input  logic                        reg1Enable_i,
    input  logic                        reg2Enable_i,
    input  logic                        reg3Enable_i,
    input  logic                        reg3IsImmediate_i,
    input  logic                        bit1_i,
    input  logic                        bit2_i,
    input  logic                        bit1Enable_i,
    input  logic                        bit2Enable_i,
    input  logic                        reg2ValOrZero_i,
    input  logic [2:0]                  functionalUnitCode_i,
    output logic                        stall_o,
    output logic                        overflow_o,
    output logic [FuCount-1:0]          fuValid_o,
    input  logic [FuCount-1:0]          fuReady_i,
    output logic [addressSize-1:0]      instructionAddress_o,
    output logic [opcodeWidth-1:0]      opcode_o,
    output logic [XxoOpcodeWidth-1:0]   xOpcode_o,
    output logic                        xOpcodeEnable_o,
    output logic [formatIndexRange-1:0] instructionFormat_o,
    output logic [immWidth-1:0]         imm_o,
    output logic                        immEnable_o,
    output logic [regWidth-1:0]         reg1_o,
    output logic [regWidth-1:0]         reg2_o,
    output logic [regWidth-1:0]         reg3_o,
    output logic [1:0]                  reg1Use_o,
    output logic [1:0]                  reg2Use_o,
    output logic [1:0]                  reg3Use_o,
    output logic                        reg1Enable_o,
    output logic                        reg2Enable_o,
    output logic                        reg3Enable_o,
    output logic                        reg3IsImmediate_o,
    output logic                        bit1_o,
    output logic                        bit2_o,
    output logic                        bit1Enable_o,
    output logic                        bit2Enable_o,
    output logic                        reg2ValOrZero_o,
    output logic [2:0]                  functionalUnitCode_o,
    output logic [CntWidth-1:0]         count_o
);

    localparam int PTR_W = $clog2(QueueDepth);

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CntWidth-1:0] r_count;
    logic                r_overflow;

    dq_entry_t           w_in_entry;
    dq_entry_t           w_head_raw;
    dq_entry_t           w_head;
    logic [ENTRY_W-1:0]  w_rd_data;
    logic                w_nonempty;
    logic                w_full;
    logic                w_deq;
    logic                w_enq;
    logic                w_drop;

    always_comb begin
        w_in_entry                      = '0;
        w_in_entry.instruction_address  = instructionAddress_i;
        w_in_entry.opcode               = opcode_i;
        w_in_entry.x_opcode             = xOpcode_i;
        w_in_entry.x_opcode_enable      = xOpcodeEnable_i;
        w_in_entry.instruction_format   = instructionFormat_i;
        w_in_entry.imm                  = imm_i;
        w_in_entry.imm_enable           = immEnable_i;
        w_in_entry.reg1                 = reg1_i;
        w_in_entry.reg2                 = reg2_i;
        w_in_entry.reg3                 = reg3_i;
        w_in_entry.reg1_use             = reg1Use_i;
        w_in_entry.reg2_use             = reg2Use_i;
        w_in_entry.reg3_use             = reg3Use_i;
        w_in_entry.reg1_enable          = reg1Enable_i;
        w_in_entry.reg2_enable          = reg2Enable_i;
        w_in_entry.reg3_enable          = reg3Enable_i;
        w_in_entry.reg3_is_immediate    = reg3IsImmediate_i;
        w_in_entry.bit1                 = bit1_i;
        w_in_entry.bit2                 = bit2_i;
        w_in_entry.bit1_enable          = bit1Enable_i;
        w_in_entry.bit2_enable          = bit2Enable_i;
        w_in_entry.reg2_val_or_zero     = reg2ValOrZero_i;
        w_in_entry.functional_unit_code = functionalUnitCode_i;
    end

    dispatch_fifo_mem #(
        .DEPTH (QueueDepth),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .i_clk     (clock_i),
        .i_wr_en   (w_enq),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_in_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign w_head_raw = dq_entry_t'(w_rd_data);
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == CntWidth'(QueueDepth));

    // Only the addressed unit's ready matters; a flush does not cancel a handshake the unit already saw.
    assign w_deq  = w_nonempty && fuReady_i[w_head_raw.functional_unit_code];
    assign w_enq  = resetn_i && enable_i && !flush_i && (!w_full || w_deq);
    assign w_drop = enable_i && !flush_i && w_full && !w_deq;

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enq && w_deq) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FuCount; gi++) begin : g_fu_valid
            assign fuValid_o[gi] = w_nonempty &&
                                   (w_head_raw.functional_unit_code == FU_CODE_W'(gi));
        end
    endgenerate

    // Stale storage must never leak out while the queue is empty.
    assign w_head = w_nonempty ? w_head_raw : '0;

    assign instructionAddress_o = w_head.instruction_address;
    assign opcode_o             = w_head.opcode;
    assign xOpcode_o            = w_head.x_opcode;
    assign xOpcodeEnable_o      = w_head.x_opcode_enable;
    assign instructionFormat_o  = w_head.instruction_format;
    assign imm_o                = w_head.imm;
    assign immEnable_o          = w_head.imm_enable;
    assign reg1_o               = w_head.reg1;
    assign reg2_o               = w_head.reg2;
    assign reg3_o               = w_head.reg3;
    assign reg1Use_o            = w_head.reg1_use;
    assign reg2Use_o            = w_head.reg2_use;
    assign reg3Use_o            = w_head.reg3_use;
    assign reg1Enable_o         = w_head.reg1_enable;
    assign reg2Enable_o         = w_head.reg2_enable;
    assign reg3Enable_o         = w_head.reg3_enable;
    assign reg3IsImmediate_o    = w_head.reg3_is_immediate;
    assign bit1_o               = w_head.bit1;
    assign bit2_o               = w_head.bit2;
    assign bit1Enable_o         = w_head.bit1_enable;
    assign bit2Enable_o         = w_head.bit2_enable;
    assign reg2ValOrZero_o      = w_head.reg2_val_or_zero;
    assign functionalUnitCode_o = w_head.functional_unit_code;

    assign stall_o    = (r_count >= CntWidth'(QueueDepth - 1));
    assign overflow_o = r_overflow;
    assign count_o    = r_count;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed plus randomized bench for dispatch_queue, checked every cycle against a
// queue-based model of the dispatch rules.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        en;
    logic [7:0]  ready;
    dq_entry_t   in_e;
    dq_entry_t   obs;
    logic        stall, ovf;
    logic [7:0]  fu_valid;
    logic [2:0]  count;

    logic [63:0] a_o; logic [5:0] op_o; logic [9:0] xo_o; logic xoe_o; logic [4:0] fmt_o;
    logic [23:0] imm_o; logic imme_o; logic [4:0] r1_o, r2_o, r3_o;
    logic [1:0]  r1u_o, r2u_o, r3u_o; logic r1e_o, r2e_o, r3e_o, r3i_o;
    logic        b1_o, b2_o, b1e_o, b2e_o, rvz_o; logic [2:0] fu_o;

    int tests = 0;
    int fails = 0;

    dq_entry_t m_q[$];
    logic      m_ovf;

    always #5 clk = ~clk;

    dispatch_queue dut (
        .clock_i(clk), .resetn_i(rstn), .flush_i(flush), .enable_i(en),
        .instructionAddress_i(in_e.instruction_address), .opcode_i(in_e.opcode),
        .xOpcode_i(in_e.x_opcode), .xOpcodeEnable_i(in_e.x_opcode_enable),
        .instructionFormat_i(in_e.instruction_format), .imm_i(in_e.imm),
        .immEnable_i(in_e.imm_enable), .reg1_i(in_e.reg1), .reg2_i(in_e.reg2),
        .reg3_i(in_e.reg3), .reg1Use_i(in_e.reg1_use), .reg2Use_i(in_e.reg2_use),
        .reg3Use_i(in_e.reg3_use), .reg1Enable_i(in_e.reg1_enable),
        .reg2Enable_i(in_e.reg2_enable), .reg3Enable_i(in_e.reg3_enable),
        .reg3IsImmediate_i(in_e.reg3_is_immediate), .bit1_i(in_e.bit1), .bit2_i(in_e.bit2),
        .bit1Enable_i(in_e.bit1_enable), .bit2Enable_i(in_e.bit2_enable),
        .reg2ValOrZero_i(in_e.reg2_val_or_zero), .functionalUnitCode_i(in_e.functional_unit_code),
        .stall_o(stall), .overflow_o(ovf), .fuValid_o(fu_valid), .fuReady_i(ready),
        .instructionAddress_o(a_o), .opcode_o(op_o), .xOpcode_o(xo_o), .xOpcodeEnable_o(xoe_o),
        .instructionFormat_o(fmt_o), .imm_o(imm_o), .immEnable_o(imme_o),
        .reg1_o(r1_o), .reg2_o(r2_o), .reg3_o(r3_o),
        .reg1Use_o(r1u_o), .reg2Use_o(r2u_o), .reg3Use_o(r3u_o),
        .reg1Enable_o(r1e_o), .reg2Enable_o(r2e_o), .reg3Enable_o(r3e_o),
        .reg3IsImmediate_o(r3i_o), .bit1_o(b1_o), .bit2_o(b2_o),
        .bit1Enable_o(b1e_o), .bit2Enable_o(b2e_o), .reg2ValOrZero_o(rvz_o),
        .functionalUnitCode_o(fu_o), .count_o(count)
    );

    always_comb begin
        obs = '{a_o, op_o, xo_o, xoe_o, fmt_o, imm_o, imme_o, r1_o, r2_o, r3_o,
                r1u_o, r2u_o, r3u_o, r1e_o, r2e_o, r3e_o, r3i_o, b1_o, b2_o,
                b1e_o, b2e_o, rvz_o, fu_o};
    end

    function automatic dq_entry_t rand_entry(input logic [2:0] fu);
        dq_entry_t e;
        e = dq_entry_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
        e.functional_unit_code = fu;
        return e;
    endfunction

    // Reference: FIFO of whole entries, head offered to unit 'fu', one drop flag.
    task automatic model_edge(input logic r, input logic f, input logic e,
                              input dq_entry_t d, input logic [7:0] rd);
        logic deq;
        logic full;
        if (!r) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            deq  = (m_q.size() > 0) && rd[m_q[0].functional_unit_code];
            full = (m_q.size() == QUEUE_DEPTH);
            if (f) begin
                m_q.delete();
            end else begin
                if (deq) void'(m_q.pop_front());
                if (e) begin
                    if (full && !deq) m_ovf = 1'b1;
                    else m_q.push_back(d);
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        dq_entry_t  exp_head;
        logic [7:0] exp_v;
        exp_head = (m_q.size() > 0) ? m_q[0] : '0;
        exp_v    = (m_q.size() > 0) ? (8'd1 << m_q[0].functional_unit_code) : 8'd0;
        tests++;
        assert (count === 3'(m_q.size())) else begin
            fails++; $error("FAIL %s count obs=%0d exp=%0d", tag, count, m_q.size());
        end
        tests++;
        assert (stall === (m_q.size() >= QUEUE_DEPTH - 1)) else begin
            fails++; $error("FAIL %s stall obs=%0b exp=%0b", tag, stall, m_q.size() >= 3);
        end
        tests++;
        assert (ovf === m_ovf) else begin
            fails++; $error("FAIL %s overflow obs=%0b exp=%0b", tag, ovf, m_ovf);
        end
        tests++;
        assert (fu_valid === exp_v) else begin
            fails++; $error("FAIL %s fuValid obs=%h exp=%h", tag, fu_valid, exp_v);
        end
        tests++;
        assert (obs === exp_head) else begin
            fails++; $error("FAIL %s head obs=%h exp=%h", tag, obs, exp_head);
        end
        $display("[TB] %s r=%0b f=%0b en=%0b rdy=%h -> cnt=%0d stall=%0b ovf=%0b v=%h addr=%h",
                 tag, rstn, flush, en, ready, count, stall, ovf, fu_valid, a_o);
    endtask

    task automatic step(input string tag, input logic r, input logic f, input logic e,
                        input dq_entry_t d, input logic [7:0] rd);
        rstn  = r;
        flush = f;
        en    = e;
        in_e  = d;
        ready = rd;
        @(posedge clk);
        model_edge(r, f, e, d, rd);
        #1;
        check_state(tag);
    endtask

    task automatic expect_val(input string tag, input logic [63:0] o, input logic [63:0] x);
        tests++;
        assert (o === x) else begin
            fails++; $error("FAIL %s obs=%h exp=%h", tag, o, x);
        end
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; en = 1'b0; ready = 8'h00; in_e = '0; m_ovf = 1'b0;
        #2;

        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'b0, 1'b1, rand_entry(3'd1), 8'hFF);
        expect_val("reset_count", 64'(count), 64'd0);

        step("single_enq", 1'b1, 1'b0, 1'b1, rand_entry(FU_MULDIV), 8'h00);
        expect_val("single_valid", 64'(fu_valid), 64'h08);
        step("single_hold", 1'b1, 1'b0, 1'b0, '0, 8'hF7);
        expect_val("single_held", 64'(fu_valid), 64'h08);
        step("single_deq", 1'b1, 1'b0, 1'b0, '0, 8'h08);
        expect_val("single_empty", 64'(count), 64'd0);

        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b1, rand_entry(3'(i + 1)), 8'h00);
        step("fill_drop", 1'b1, 1'b0, 1'b1, rand_entry(3'd6), 8'h00);
        expect_val("drop_ovf", 64'(ovf), 64'd1);
        expect_val("drop_count", 64'(count), 64'd4);
        step("full_enq_deq", 1'b1, 1'b0, 1'b1, rand_entry(3'd7), 8'h02);
        expect_val("full_enq_deq_count", 64'(count), 64'd4);

        step("rst_clear", 1'b0, 1'b0, 1'b0, '0, 8'h00);
        step("order_a", 1'b1, 1'b0, 1'b1, rand_entry(FU_INT1), 8'h20);
        step("order_b", 1'b1, 1'b0, 1'b1, rand_entry(FU_STORE), 8'h20);
        for (int i = 0; i < 3; i++) step("order_block", 1'b1, 1'b0, 1'b0, '0, 8'h20);
        expect_val("order_blocked", 64'(count), 64'd2);
        step("order_rel1", 1'b1, 1'b0, 1'b0, '0, 8'h24);
        step("order_rel2", 1'b1, 1'b0, 1'b0, '0, 8'h24);
        expect_val("order_drained", 64'(count), 64'd0);

        for (int i = 0; i < 3; i++) step("pre_flush", 1'b1, 1'b0, 1'b1, rand_entry(3'(i)), 8'h00);
        step("flush_enq", 1'b1, 1'b1, 1'b1, rand_entry(3'd4), 8'h00);
        expect_val("flush_count", 64'(count), 64'd0);

        for (int i = 0; i < 10; i++) step("wrap", 1'b1, 1'b0, 1'b1, rand_entry(3'($urandom_range(7))),
                                          8'($urandom));

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(99) != 0), ($urandom_range(31) == 0),
                 ($urandom_range(3) != 0), rand_entry(3'($urandom_range(7))), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
